sprite_pos_regs: RTL and testbench

SPRITE_POS_REGS -- requirements
Module: sprite_pos_regs

---
 rtl/sprite_pos_regs.sv | 152 +++++++++++++++
 tb/tb_sprite_pos_regs.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/sprite_pos_regs.sv
`default_nettype none
// ============================================================================
// Module      : sprite_pos_regs
// Description : CPU-visible double-buffered sprite position registers.
//               The CPU writes six shadow registers (mx, my, p1x, p1y, p2x,
//               p2y). It then arms a commit through CTRL. The shadows are
//               copied to the active outputs on the next vertical-sync
//               falling edge, so the VGA stage never sees a half-updated
//               frame. The block also keeps a frame counter that advances
//               on every commit.
// Ports       : clk        - system clock (single domain)
//               reset      - asynchronous active-low reset
//               we / re    - one-cycle CPU write / read strobes
//               addr       - CPU address; 8-word window at BASE_ADDR
//               wdata      - CPU write data
//               rdata      - registered read data (1-cycle latency)
//               v_sync     - active-low vertical sync, clk domain
//               mx..p2y    - active sprite positions
//               frame_irq  - one-cycle pulse on each commit
// Revision    : 1.0 - initial release
// ============================================================================
module sprite_pos_regs #(
  parameter logic [15:0] BASE_ADDR = 16'hFFF0,
  parameter int unsigned X_MAX     = 639,
  parameter int unsigned Y_MAX     = 479
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        we,
  input  logic        re,
  input  logic [15:0] addr,
  input  logic [15:0] wdata,
  output logic [15:0] rdata,
  input  logic        v_sync,
  output logic [15:0] mx,
  output logic [15:0] my,
  output logic [15:0] p1x,
  output logic [15:0] p1y,
  output logic [15:0] p2x,
  output logic [15:0] p2y,
  output logic        frame_irq
);

  localparam logic [15:0] C_X_LIM = 16'(X_MAX);
  localparam logic [15:0] C_Y_LIM = 16'(Y_MAX);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ARMED = 2'd1,
    ST_COPY  = 2'd2
  } state_t;

  state_t      r_state;
  state_t      w_state_nxt;
  logic [15:0] r_shadow [0:5];
  logic [15:0] r_active [0:5];
  logic [15:0] r_frame_cnt;
  logic [15:0] r_rdata;
  logic        r_vs_q;

  logic        w_hit;
  logic [2:0]  w_off;
  logic        w_commit_req;
  logic        w_vsync_fall;
  logic        w_copy;
  logic        w_armed;
  logic        w_vblank;
  logic [15:0] w_wr_val;
  logic [15:0] w_rd_val;

  assign w_hit        = (addr[15:3] == BASE_ADDR[15:3]);
  assign w_off        = addr[2:0];
  assign w_commit_req = we && w_hit && (w_off == 3'd6) && wdata[0];
  assign w_vsync_fall = r_vs_q && !v_sync;
  assign w_copy       = (r_state == ST_COPY);
  assign w_armed      = (r_state == ST_ARMED);
  assign w_vblank     = !r_vs_q;

  // Even offsets hold X coordinates and odd offsets hold Y coordinates.
  // Each value saturates to the limit for its axis.
  always_comb begin
    w_wr_val = wdata;
    if (!w_off[0]) begin
      if (wdata > C_X_LIM) w_wr_val = C_X_LIM;
    end else begin
      if (wdata > C_Y_LIM) w_wr_val = C_Y_LIM;
    end
  end

  always_comb begin
    w_rd_val = 16'h0000;
    case (w_off)
      3'd6:    w_rd_val = {14'b0, w_vblank, w_armed};
      3'd7:    w_rd_val = r_frame_cnt;
      default: w_rd_val = r_shadow[w_off];
    endcase
  end

  // A commit that arrives during COPY re-arms the FSM for the next frame.
  // In ARMED, a repeated commit has no further effect.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:  if (w_commit_req) w_state_nxt = ST_ARMED;
      ST_ARMED: if (w_vsync_fall) w_state_nxt = ST_COPY;
      ST_COPY:  w_state_nxt = w_commit_req ? ST_ARMED : ST_IDLE;
      default:  w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= ST_IDLE;
      r_vs_q  <= 1'b1;
    end else begin
      r_state <= w_state_nxt;
      r_vs_q  <= v_sync;
    end
  end

  // The non-blocking copy takes the shadow value from before any write in
  // the same cycle. Likewise, a read that collides with a write returns
  // the old value.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < 6; i++) begin
        r_shadow[i] <= 16'h0000;
        r_active[i] <= 16'h0000;
      end
      r_frame_cnt <= 16'h0000;
      r_rdata     <= 16'h0000;
    end else begin
      if (we && w_hit && (w_off < 3'd6)) r_shadow[w_off] <= w_wr_val;
      if (w_copy) begin
        for (int i = 0; i < 6; i++) r_active[i] <= r_shadow[i];
        r_frame_cnt <= r_frame_cnt + 16'd1;
      end
      if (re && w_hit) r_rdata <= w_rd_val;
    end
  end

  assign rdata     = r_rdata;
  assign mx        = r_active[0];
  assign my        = r_active[1];
  assign p1x       = r_active[2];
  assign p1y       = r_active[3];
  assign p2x       = r_active[4];
  assign p2y       = r_active[5];
  assign frame_irq = w_copy;

endmodule
`default_nettype wire

// File: tb/tb_sprite_pos_regs.sv
`default_nettype none
// ============================================================================
// Module      : tb_sprite_pos_regs
// Description : Directed self-checking bench for sprite_pos_regs.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sprite_pos_regs;

  localparam logic [15:0] C_BASE = 16'hFFF0;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        we = 1'b0;
  logic        re = 1'b0;
  logic [15:0] addr = 16'h0000;
  logic [15:0] wdata = 16'h0000;
  logic        v_sync = 1'b1;
  logic [15:0] rdata;
  logic [15:0] mx, my, p1x, p1y, p2x, p2y;
  logic        frame_irq;
  logic [15:0] v;

  int total = 0;
  int bad   = 0;

  sprite_pos_regs dut (
    .clk       (clk),
    .reset     (reset),
    .we        (we),
    .re        (re),
    .addr      (addr),
    .wdata     (wdata),
    .rdata     (rdata),
    .v_sync    (v_sync),
    .mx        (mx),
    .my        (my),
    .p1x       (p1x),
    .p1y       (p1y),
    .p2x       (p2x),
    .p2y       (p2y),
    .frame_irq (frame_irq)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic wr_raw(input logic [15:0] a, input logic [15:0] d);
    addr  = a;
    wdata = d;
    we    = 1'b1;
    tick();
    we    = 1'b0;
  endtask

  task automatic wr(input logic [2:0] off, input logic [15:0] d);
    wr_raw(C_BASE + {13'b0, off}, d);
  endtask

  task automatic rd(input logic [2:0] off, output logic [15:0] val);
    addr = C_BASE + {13'b0, off};
    re   = 1'b1;
    tick();
    re   = 1'b0;
    val  = rdata;
  endtask

  task automatic frame;
    v_sync = 1'b0;
    tick();
    tick();
    v_sync = 1'b1;
    tick();
  endtask

  initial begin
    // Reset state
    tick(); tick();
    chk("rst_mx", mx, 16'd0);
    chk("rst_p2y", p2y, 16'd0);
    chk("rst_rdata", rdata, 16'd0);
    chk("rst_irq", {15'b0, frame_irq}, 16'd0);
    reset = 1'b1;
    tick();
    rd(3'd6, v); chk("status_idle", v, 16'h0000);

    // Commit without a v_sync edge: only armed
    wr(3'd0, 16'd100);
    wr(3'd6, 16'h0001);
    rd(3'd0, v); chk("shadow_mx", v, 16'd100);
    rd(3'd6, v); chk("status_armed", v, 16'h0001);
    chk("mx_held", mx, 16'd0);

    // Falling v_sync: edge detect, then COPY, then outputs visible
    v_sync = 1'b0;
    tick();
    chk("irq_copy", {15'b0, frame_irq}, 16'd1);
    chk("mx_in_copy", mx, 16'd0);
    tick();
    chk("mx_after", mx, 16'd100);
    chk("irq_done", {15'b0, frame_irq}, 16'd0);
    rd(3'd7, v); chk("cnt1", v, 16'd1);
    rd(3'd6, v); chk("status_vblank", v, 16'h0002);
    v_sync = 1'b1;
    tick();

    // Saturation
    wr(3'd2, 16'h0400);
    wr(3'd3, 16'h01F0);
    rd(3'd2, v); chk("p1x_sat", v, 16'd639);
    rd(3'd3, v); chk("p1y_sat", v, 16'd479);
    wr(3'd0, 16'd639);
    wr(3'd1, 16'd300);
    wr(3'd5, 16'hFFFF);
    rd(3'd0, v); chk("mx_edge", v, 16'd639);
    rd(3'd1, v); chk("my_below", v, 16'd300);
    rd(3'd5, v); chk("p2y_sat", v, 16'd479);

    // Simultaneous write and read to offset 4: old value returned
    addr  = C_BASE + 16'd4;
    wdata = 16'd5;
    we    = 1'b1;
    re    = 1'b1;
    tick();
    we    = 1'b0;
    re    = 1'b0;
    chk("rw_collide", rdata, 16'd0);
    rd(3'd4, v); chk("p2x_sh5", v, 16'd5);

    // Shadow write during COPY
    wr(3'd6, 16'h0001);
    v_sync = 1'b0;
    tick();
    wr(3'd4, 16'd7);
    chk("p2x_pre", p2x, 16'd5);
    chk("mx_c2", mx, 16'd639);
    chk("my_c2", my, 16'd300);
    chk("p1x_c2", p1x, 16'd639);
    chk("p1y_c2", p1y, 16'd479);
    chk("p2y_c2", p2y, 16'd479);
    v_sync = 1'b1;
    tick();
    rd(3'd4, v); chk("p2x_sh7", v, 16'd7);
    wr(3'd6, 16'h0001);
    frame();
    chk("p2x_new", p2x, 16'd7);

    // Commit during COPY re-arms
    wr(3'd6, 16'h0001);
    v_sync = 1'b0;
    tick();
    wr(3'd6, 16'h0001);
    rd(3'd6, v); chk("rearm", v, 16'h0003);
    v_sync = 1'b1;
    tick();
    frame();
    rd(3'd7, v); chk("cnt5", v, 16'd5);

    // Address miss on read holds rdata
    addr = 16'hFFE7;
    re   = 1'b1;
    tick();
    re   = 1'b0;
    chk("rd_miss", rdata, 16'd5);

    // Events that must not commit or count
    frame();
    rd(3'd7, v); chk("idle_fall", v, 16'd5);
    wr(3'd7, 16'h1234);
    rd(3'd7, v); chk("cnt_ro", v, 16'd5);
    wr(3'd6, 16'hFFFE);
    rd(3'd6, v); chk("ctrl_nop", v, 16'h0000);
    frame();
    rd(3'd7, v); chk("no_arm", v, 16'd5);
    wr(3'd0, 16'd10);
    chk("mx_no_commit", mx, 16'd639);
    wr_raw(16'hFFF8, 16'd42);
    rd(3'd0, v); chk("wr_miss", v, 16'd10);

    // Frame counter wrap
    force dut.r_frame_cnt = 16'hFFFF;
    tick();
    release dut.r_frame_cnt;
    rd(3'd7, v); chk("cnt_ffff", v, 16'hFFFF);
    wr(3'd6, 16'h0001);
    frame();
    rd(3'd7, v); chk("cnt_wrap", v, 16'h0000);
    chk("mx_wrap", mx, 16'd10);

    // Reset while ARMED
    wr(3'd1, 16'd77);
    wr(3'd6, 16'h0001);
    rd(3'd6, v); chk("armed_pre_rst", v, 16'h0001);
    reset = 1'b0;
    #2;
    chk("arst_mx", mx, 16'd0);
    chk("arst_p2x", p2x, 16'd0);
    chk("arst_rdata", rdata, 16'd0);
    tick();
    reset = 1'b1;
    rd(3'd6, v); chk("idle_post_rst", v, 16'h0000);
    v_sync = 1'b0;
    tick();
    chk("no_irq_post_rst", {15'b0, frame_irq}, 16'd0);
    tick();
    chk("my_post_rst", my, 16'd0);
    v_sync = 1'b1;
    tick();
    rd(3'd7, v); chk("cnt_post_rst", v, 16'd0);
    rd(3'd1, v); chk("my_sh_post_rst", v, 16'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
